// File: rtl/uart_pkg.sv
// Shared UART definitions: payload limits, parity encoding and frame-length helper
// used by both the receive and transmit frontends.
`default_nettype none

package uart_pkg;

  localparam int MIN_PACKET_SIZE = 8;
  localparam int MAX_PACKET_SIZE = 11;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  // Total line bits: start + 7/8 data + optional parity + 1/2 stop.
  function automatic logic [3:0] frame_length(input logic ds, input logic [1:0] p,
                                               input logic s);
    return 4'd9 + {3'b000, ds} + {3'b000, (p != PARITY_NONE)} + {3'b000, s};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_frontend.sv
// UART transmitter: accepts one character per valid/ready handshake and
// serialises start, data (LSB first), optional parity and stop bits.
`default_nettype none

module tx_frontend
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] cr_clk_div_i,
  input  logic        cr_ds_i,
  input  logic [1:0]  cr_p_i,
  input  logic        cr_s_i,
  input  logic [7:0]  data_i,
  input  logic        input_valid_i,
  output logic        ready_o,
  output logic        uart_tx_o,
  output logic        done_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state, state_next;
  logic [11:0] shift_reg;
  logic [11:0] frame_init;
  logic [15:0] baud_cnt;
  logic [15:0] baud_reload;
  logic [15:0] div_m1;
  logic [3:0]  bit_cnt;
  logic [3:0]  frame_len;
  logic        parity_bit;
  logic        accept;
  logic        bit_end;
  logic        last_bit;

  assign accept    = input_valid_i && ready_o;
  assign bit_end   = (state == SEND) && (baud_cnt == 16'd0);
  assign last_bit  = (bit_cnt == frame_len - 4'd1);
  assign done_o    = bit_end && last_bit;
  // The line is the LSB of the shift register, so it is a flop output and
  // idles high because shifts and reset fill with ones.
  assign uart_tx_o = shift_reg[0];

  assign div_m1     = (cr_clk_div_i <= 16'd1) ? 16'd0 : cr_clk_div_i - 16'd1;
  assign parity_bit = (^(data_i & {cr_ds_i, 7'h7F})) ^ cr_p_i[1];

  always_comb begin
    frame_init    = '1;
    frame_init[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 7 || cr_ds_i) frame_init[i+1] = data_i[i];
    end
    if (cr_p_i != PARITY_NONE) frame_init[{3'b000, cr_ds_i} + 4'd8] = parity_bit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SEND;
      SEND:    if (done_o) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_reg   <= '1;
      baud_cnt    <= 16'd0;
      baud_reload <= 16'd0;
      bit_cnt     <= 4'd0;
      frame_len   <= 4'd0;
      ready_o     <= 1'b1;
    end else begin
      ready_o <= (state_next == IDLE);
      if (accept) begin
        shift_reg   <= frame_init;
        frame_len   <= frame_length(cr_ds_i, cr_p_i, cr_s_i);
        baud_reload <= div_m1;
        baud_cnt    <= div_m1;
        bit_cnt     <= 4'd0;
      end else if (bit_end) begin
        shift_reg <= {1'b1, shift_reg[11:1]};
        baud_cnt  <= baud_reload;
        bit_cnt   <= last_bit ? 4'd0 : bit_cnt + 4'd1;
      end else if (state == SEND) begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tx_frontend.sv
// Self-checking bench for tx_frontend: per-cycle line model plus directed literal checks.
`default_nettype none

module tb_tx_frontend;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] cr_clk_div_i;
  logic        cr_ds_i;
  logic [1:0]  cr_p_i;
  logic        cr_s_i;
  logic [7:0]  data_i;
  logic        input_valid_i;
  logic        ready_o;
  logic        uart_tx_o;
  logic        done_o;

  tx_frontend dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cr_clk_div_i  (cr_clk_div_i),
    .cr_ds_i       (cr_ds_i),
    .cr_p_i        (cr_p_i),
    .cr_s_i        (cr_s_i),
    .data_i        (data_i),
    .input_valid_i (input_valid_i),
    .ready_o       (ready_o),
    .uart_tx_o     (uart_tx_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic tx;
    logic done;
    logic rdy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   done_cyc = -1;
  bit   model_en = 0;
  logic tx_log [65536];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the frame is a list of line levels, each held D cycles.
  task automatic push_frame(input logic [7:0] d, input logic [15:0] div, input logic ds,
                            input logic [1:0] p, input logic s);
    logic bits[$];
    int   dl;
    int   ones;
    exp_t e;
    dl = (div < 2) ? 1 : int'(div);
    bits.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < 7 + int'(ds); i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (p != 2'b00) bits.push_back((p == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0));
    bits.push_back(1'b1);
    if (s) bits.push_back(1'b1);
    for (int j = 0; j < bits.size(); j++) begin
      for (int k = 0; k < dl; k++) begin
        e.tx   = bits[j];
        e.done = (j == bits.size() - 1) && (k == dl - 1);
        e.rdy  = 1'b0;
        q.push_back(e);
      end
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (model_en) begin
      if (q.size() > 0) e = q.pop_front();
      else begin
        e.tx = 1'b1; e.done = 1'b0; e.rdy = 1'b1;
      end
      chk("uart_tx", uart_tx_o, e.tx);
      chk("done", done_o, e.done);
      chk("ready", ready_o, e.rdy);
      tx_log[cyc % 65536] = uart_tx_o;
      if (done_o) done_cyc = cyc;
      if (rst_i) q.delete();
      else if (input_valid_i && e.rdy) begin
        acc_cyc  = cyc;
        done_cyc = -1;
        push_frame(data_i, cr_clk_div_i, cr_ds_i, cr_p_i, cr_s_i);
      end
    end
    cyc++;
  end

  task automatic drive(input logic [7:0] d, input logic [15:0] div, input logic ds,
                       input logic [1:0] p, input logic s);
    data_i = d; cr_clk_div_i = div; cr_ds_i = ds; cr_p_i = p; cr_s_i = s;
  endtask

  // Holds valid until the DUT takes the character; leaves valid high if hold is set.
  task automatic wait_accept(input string name, input bit hold);
    bit got;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk_i);
      if (ready_o) got = 1;
    end
    if (!got) chk({name, "_accept_timeout"}, 0, 1);
    @(posedge clk_i); #1;
    if (!hold) input_valid_i = 1'b0;
  endtask

  task automatic send(input string name, input logic [7:0] d, input logic [15:0] div,
                      input logic ds, input logic [1:0] p, input logic s);
    @(posedge clk_i); #1;
    drive(d, div, ds, p, s);
    input_valid_i = 1'b1;
    wait_accept(name, 0);
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 0;
    for (int i = 0; i < 5000 && !idle; i++) begin
      @(posedge clk_i);
      if (q.size() == 0) idle = 1;
    end
    if (!idle) chk({name, "_idle_timeout"}, 0, 1);
    #1;
  endtask

  task automatic check_frame(input string name, input int n, input int dl,
                             input logic [11:0] pattern);
    chk({name, "_done_latency"}, done_cyc - acc_cyc, n * dl);
    for (int j = 0; j < n; j++)
      chk({name, "_bit"}, tx_log[(acc_cyc + 1 + j * dl) % 65536], pattern[j]);
  endtask

  initial begin
    int acc1;
    int acc2;
    rst_i = 1'b1;
    input_valid_i = 1'b0;
    drive(8'h00, 16'd4, 1'b1, 2'b00, 1'b0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_en = 1;
    @(negedge clk_i);
    chk("reset_tx", uart_tx_o, 1);
    chk("reset_ready", ready_o, 1);
    chk("reset_done", done_o, 0);

    send("8n1", 8'h55, 16'd4, 1'b1, 2'b00, 1'b0);
    wait_idle("8n1");
    check_frame("8n1", 10, 4, 12'b0010_1010_1010);

    send("8e1_07", 8'h07, 16'd3, 1'b1, 2'b01, 1'b0);
    wait_idle("8e1_07");
    check_frame("8e1_07", 11, 3, 12'b0110_0000_1110);
    send("8e1_03", 8'h03, 16'd3, 1'b1, 2'b01, 1'b0);
    wait_idle("8e1_03");
    chk("8e1_03_parity", tx_log[(acc_cyc + 1 + 9 * 3) % 65536], 0);

    send("7o2", 8'hFF, 16'd2, 1'b0, 2'b10, 1'b1);
    wait_idle("7o2");
    check_frame("7o2", 11, 2, 12'b0110_1111_1110);

    @(posedge clk_i); #1;
    drive(8'hA5, 16'd1, 1'b1, 2'b00, 1'b0);
    input_valid_i = 1'b1;
    wait_accept("b2b_first", 1);
    acc1 = acc_cyc;
    data_i = 8'h3C;
    wait_accept("b2b_second", 0);
    acc2 = acc_cyc;
    chk("b2b_start_spacing", acc2 - acc1, 11);
    wait_idle("b2b");
    check_frame("b2b_3c", 10, 1, 12'b0010_0111_1000);

    send("cfg_a", 8'h55, 16'd4, 1'b1, 2'b00, 1'b0);
    while (cyc < acc_cyc + 14) @(posedge clk_i);
    #1 cr_clk_div_i = 16'd8;
    wait_idle("cfg_a");
    check_frame("cfg_a", 10, 4, 12'b0010_1010_1010);
    send("cfg_b", 8'h55, 16'd8, 1'b1, 2'b00, 1'b0);
    wait_idle("cfg_b");
    chk("cfg_b_done_latency", done_cyc - acc_cyc, 80);

    send("rst_mid", 8'h55, 16'd4, 1'b1, 2'b00, 1'b0);
    while (cyc < acc_cyc + 14) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_tx", uart_tx_o, 1);
    chk("rst_mid_ready", ready_o, 1);
    chk("rst_mid_done", done_o, 0);
    send("rst_fresh", 8'h55, 16'd4, 1'b1, 2'b00, 1'b0);
    wait_idle("rst_fresh");
    check_frame("rst_fresh", 10, 4, 12'b0010_1010_1010);

    // Random traffic with free-running config changes and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk_i); #1;
      input_valid_i = ($urandom_range(0, 3) == 0);
      drive(8'($urandom), 16'($urandom_range(0, 4)), 1'($urandom), 2'($urandom),
            1'($urandom));
      rst_i = ($urandom_range(0, 699) == 0);
    end
    @(posedge clk_i); #1;
    input_valid_i = 1'b0;
    rst_i = 1'b0;
    wait_idle("random");
    repeat (3) @(posedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
